// File: rtl/rsa_decrypt_engine.sv
// Flow-controlled RSA decrypt: pt = ct^d mod n, constant-time right-to-left square-and-multiply.
// Result 1+W*(W+1) edges after accept (error marker after 1); ct_ready only in IDLE, result held until pt_ready.
module rsa_decrypt_engine #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [W-1:0] d_in,
    input  logic [W-1:0] n_in,
    input  logic         ct_valid,
    output logic         ct_ready,
    input  logic [W-1:0] ct_data,
    output logic         pt_valid,
    input  logic         pt_ready,
    output logic [W-1:0] pt_data,
    output logic         pt_err,
    output logic         busy
);
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_STEP, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  d_q, d_d, n_q, n_d;
    logic [W-1:0]  res_q, res_d, base_q, base_d, exp_q, exp_d, mb_q, mb_d;
    logic [W-1:0]  acc_r_q, acc_r_d, acc_b_q, acc_b_d;
    logic [CW-1:0] cnt_q, cnt_d, ebit_q, ebit_d;
    logic          pt_valid_q, pt_valid_d, pt_err_q, pt_err_d;
    logic [W-1:0]  pt_data_q, pt_data_d;

    // One interleaved-multiply step: (2*acc + (b ? addend : 0)) mod n, each mod a single subtract.
    function automatic logic [W-1:0] mod_mac(input logic [W-1:0] acc, input logic b,
                                             input logic [W-1:0] addend, input logic [W-1:0] n);
        logic [W:0] t;
        t = {acc, 1'b0};
        if (t >= {1'b0, n}) t = t - {1'b0, n};
        t = {1'b0, t[W-1:0]} + (b ? {1'b0, addend} : '0);
        if (t >= {1'b0, n}) t = t - {1'b0, n};
        return t[W-1:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        n_d        = n_q;
        res_d      = res_q;
        base_d     = base_q;
        exp_d      = exp_q;
        mb_d       = mb_q;
        acc_r_d    = acc_r_q;
        acc_b_d    = acc_b_q;
        cnt_d      = cnt_q;
        ebit_d     = ebit_q;
        pt_valid_d = pt_valid_q;
        pt_err_d   = pt_err_q;
        pt_data_d  = pt_data_q;
        case (state_q)
            S_IDLE: begin
                // A same-cycle ct handshake wins: the key stays as the accepted ct expects.
                if (ct_valid) begin
                    base_d  = ct_data;
                    state_d = S_LOAD;
                end else if (key_load) begin
                    d_d = d_in;
                    n_d = n_in;
                end
            end
            S_LOAD: begin
                if (n_q < W'(2) || base_q >= n_q) begin
                    pt_valid_d = 1'b1;
                    pt_err_d   = 1'b1;
                    pt_data_d  = '0;
                    state_d    = S_DONE;
                end else begin
                    res_d   = W'(1);
                    exp_d   = d_q;
                    mb_d    = base_q;
                    acc_r_d = '0;
                    acc_b_d = '0;
                    cnt_d   = CW'(W - 1);
                    ebit_d  = CW'(W - 1);
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_r_d = mod_mac(acc_r_q, mb_q[W-1], res_q, n_q);
                acc_b_d = mod_mac(acc_b_q, mb_q[W-1], base_q, n_q);
                mb_d    = mb_q << 1;
                if (cnt_q == '0) state_d = S_STEP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_STEP: begin
                if (exp_q[0]) res_d = acc_r_q;
                base_d  = acc_b_q;
                exp_d   = exp_q >> 1;
                mb_d    = acc_b_q;
                acc_r_d = '0;
                acc_b_d = '0;
                if (ebit_q == '0) begin
                    pt_valid_d = 1'b1;
                    pt_err_d   = 1'b0;
                    pt_data_d  = exp_q[0] ? acc_r_q : res_q;
                    state_d    = S_DONE;
                end else begin
                    ebit_d  = ebit_q - 1'b1;
                    cnt_d   = CW'(W - 1);
                    state_d = S_MUL;
                end
            end
            S_DONE: begin
                if (pt_ready) begin
                    pt_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            d_q        <= '0;
            n_q        <= '0;
            res_q      <= '0;
            base_q     <= '0;
            exp_q      <= '0;
            mb_q       <= '0;
            acc_r_q    <= '0;
            acc_b_q    <= '0;
            cnt_q      <= '0;
            ebit_q     <= '0;
            pt_valid_q <= 1'b0;
            pt_err_q   <= 1'b0;
            pt_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            n_q        <= n_d;
            res_q      <= res_d;
            base_q     <= base_d;
            exp_q      <= exp_d;
            mb_q       <= mb_d;
            acc_r_q    <= acc_r_d;
            acc_b_q    <= acc_b_d;
            cnt_q      <= cnt_d;
            ebit_q     <= ebit_d;
            pt_valid_q <= pt_valid_d;
            pt_err_q   <= pt_err_d;
            pt_data_q  <= pt_data_d;
        end
    end

    assign ct_ready = (state_q == S_IDLE);
    assign busy     = (state_q == S_LOAD) || (state_q == S_MUL) || (state_q == S_STEP);
    assign pt_valid = pt_valid_q;
    assign pt_err   = pt_err_q;
    assign pt_data  = pt_data_q;
endmodule

// File: tb/tb_rsa_decrypt_engine.sv
// Self-checking bench for rsa_decrypt_engine against a plain-arithmetic modular exponentiation model.
module tb_rsa_decrypt_engine;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst, key_load, ct_valid, ct_ready, pt_valid, pt_ready, pt_err, busy;
    logic [W-1:0] d_in, n_in, ct_data, pt_data;

    int n_chk = 0;
    int n_bad = 0;

    rsa_decrypt_engine #(.W(W)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .d_in(d_in), .n_in(n_in),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .pt_err(pt_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] ref_pow(input longint c, input longint e, input longint m);
        longint r, b;
        r = 1;
        b = c % m;
        for (int i = 0; i < W; i++) begin
            if (e[0]) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return W'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [W-1:0] d, input logic [W-1:0] n);
        key_load = 1'b1;
        d_in     = d;
        n_in     = n;
        tick();
        key_load = 1'b0;
    endtask

    // Returns after the accept edge.
    task automatic send_ct(input logic [W-1:0] ct);
        int g;
        ct_data  = ct;
        ct_valid = 1'b1;
        g = 0;
        while (!ct_ready && g < 2000) begin
            tick();
            g++;
        end
        if (!ct_ready) chk("ct_ready_timeout", 0, 1);
        tick();
        ct_valid = 1'b0;
    endtask

    task automatic finish_pt(input string tag, input logic [W-1:0] want, input logic want_err,
                             input int lat, input bit pop);
        int edges, rdy_hi;
        edges  = 0;
        rdy_hi = 0;
        do begin
            tick();
            edges++;
            if (ct_ready && !pt_valid) rdy_hi++;
        end while (!pt_valid && edges < 3000);
        chk({tag, "_valid"}, pt_valid, 1);
        if (lat >= 0) chk({tag, "_lat"}, edges, lat);
        chk({tag, "_data"}, pt_data, want);
        chk({tag, "_err"}, pt_err, want_err);
        chk({tag, "_rdy_low"}, rdy_hi, 0);
        if (pop) begin
            pt_ready = 1'b1;
            tick();
            pt_ready = 1'b0;
        end
    endtask

    initial begin
        int          cnt;
        logic [W-1:0] rn, rd, rc;
        logic        re;
        rst = 1'b1; key_load = 1'b0; d_in = '0; n_in = '0;
        ct_valid = 1'b0; ct_data = '0; pt_ready = 1'b0;
        tick();
        tick();
        chk("rst_pt_valid", pt_valid, 0);
        chk("rst_pt_data", pt_data, 0);
        chk("rst_pt_err", pt_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ct_ready", ct_ready, 1);
        rst = 1'b0;
        tick();

        // Textbook key: n=3233, d=2753, 2790 -> 65.
        load_key(24'd2753, 24'd3233);
        send_ct(24'd2790);
        chk("accept_busy", busy, 1);
        chk("accept_ct_ready", ct_ready, 0);
        finish_pt("basic", 24'd65, 1'b0, 601, 1'b1);

        pt_ready = 1'b1;
        send_ct(24'd2790); finish_pt("b2b0", 24'd65, 1'b0, 601, 1'b0);
        send_ct(24'd0);    finish_pt("b2b1", 24'd0,  1'b0, 601, 1'b0);
        send_ct(24'd1);    finish_pt("b2b2", 24'd1,  1'b0, 601, 1'b0);
        tick();
        pt_ready = 1'b0;

        send_ct(24'd3233); finish_pt("ct_eq_n", 24'd0, 1'b1, 1, 1'b1);
        load_key(24'd5, 24'd1);
        send_ct(24'd0);    finish_pt("n_one", 24'd0, 1'b1, 1, 1'b1);
        load_key(24'd2753, 24'd3233);

        // Result must hold under backpressure.
        send_ct(24'd2790);
        finish_pt("bp", 24'd65, 1'b0, 601, 1'b0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!pt_valid || pt_data != 24'd65 || ct_ready) cnt++;
        end
        chk("bp_hold", cnt, 0);
        pt_ready = 1'b1;
        tick();
        pt_ready = 1'b0;
        chk("bp_release_valid", pt_valid, 0);
        chk("bp_release_ready", ct_ready, 1);

        // key_load while busy is ignored.
        send_ct(24'd2790);
        repeat (20) tick();
        load_key(24'd17, 24'd3233);
        finish_pt("kl_busy", 24'd65, 1'b0, -1, 1'b1);
        send_ct(24'd2790); finish_pt("kl_busy_after", 24'd65, 1'b0, 601, 1'b1);

        // key_load in the same cycle as the ct handshake is ignored.
        key_load = 1'b1; d_in = 24'd17; n_in = 24'd3000;
        send_ct(24'd2790);
        key_load = 1'b0;
        finish_pt("kl_same", 24'd65, 1'b0, 601, 1'b1);
        send_ct(24'd3100);
        finish_pt("kl_same_n", ref_pow(3100, 2753, 3233), 1'b0, 601, 1'b1);

        // Random keys and ciphertexts, some out of range.
        for (int i = 0; i < 10; i++) begin
            rn = W'($urandom_range(24'hFFFFFF, 2));
            rd = W'($urandom);
            if (i % 4 == 3) rc = W'($urandom_range(24'hFFFFFF, int'(rn)));
            else            rc = W'($urandom % int'(rn));
            if (i == 1) rd = '0;
            re = (rc >= rn);
            load_key(rd, rn);
            send_ct(rc);
            finish_pt($sformatf("rand%0d", i), re ? '0 : ref_pow(rc, rd, rn), re, re ? 1 : 601, 1'b1);
        end

        // Reset mid-computation.
        load_key(24'd2753, 24'd3233);
        send_ct(24'd2790);
        repeat (300) tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", pt_valid, 0);
        chk("mid_rst_data", pt_data, 0);
        chk("mid_rst_err", pt_err, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ct_ready, 1);
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (pt_valid) cnt++;
        end
        chk("mid_rst_no_result", cnt, 0);
        send_ct(24'd5);
        finish_pt("mid_rst_key_clear", 24'd0, 1'b1, 1, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
